contador_datos_multi: RTL and testbench

//  Parametrised multi-channel up/down data counter driven by push-button step inputs.

---
 rtl/contador_pkg.sv | 28 ++
 rtl/key_step.sv | 78 +++++++
 rtl/contador_datos_multi.sv | 167 ++++++++++++++++
 tb/tb_contador_datos_multi.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// Shared constants and types for the multi-channel data counter.
// Contents:
//   MODE_WRAP / MODE_SAT  values of the mode input
//   step_e                decoded step request for the selected channel
package contador_pkg;

   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   typedef enum logic [1:0] {
      STEP_NONE = 2'd0,
      STEP_UP   = 2'd1,
      STEP_DN   = 2'd2
   } step_e;

   // Decode the two button step strobes; simultaneous presses cancel out.
   function automatic step_e decode_step(input logic up_s, input logic dn_s);
      step_e s;
      s = STEP_NONE;
      if (up_s && !dn_s) begin
         s = STEP_UP;
      end else if (dn_s && !up_s) begin
         s = STEP_DN;
      end
      return s;
   endfunction

endpackage

// File: rtl/key_step.sv
// Push-button step generator: rising-edge detector with optional auto-repeat.
// Build option: define AUTOREPEAT_EN to build the hold/repeat timer.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   btn_i        debounced button level
//   other_i      level of the opposing button (holding both stops repeat)
//   en_i, clr_i  repeat runs only with en_i=1 and clr_i=0
//   step_c       combinational 1-cycle step strobe
module key_step #(
   parameter int unsigned HOLD_CYCLES   = 50,
   parameter int unsigned REPEAT_CYCLES = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   input  logic other_i,
   input  logic en_i,
   input  logic clr_i,
   output logic step_c
);

   logic btn_q;
   logic edge_c;

   // Button history, sampled every cycle regardless of en/clr.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_q <= 1'b0;
      end else begin
         btn_q <= btn_i;
      end
   end

   assign edge_c = btn_i & ~btn_q;

`ifdef AUTOREPEAT_EN
   localparam int unsigned TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

   logic [TW-1:0] hold_q;
   logic [TW-1:0] hold_d;
   logic          held_c;
   logic          rpt_c;

   // Timer value equals cycles since the press; reaching HOLD_CYCLES emits a
   // step and rewinds so the next hit lands REPEAT_CYCLES later.
   assign held_c = btn_i & ~other_i & en_i & ~clr_i;
   assign rpt_c  = held_c && (hold_q == TW'(HOLD_CYCLES));

   always_comb begin
      hold_d = hold_q;
      if (!held_c) begin
         hold_d = '0;
      end else if (rpt_c) begin
         hold_d = TW'(HOLD_CYCLES - REPEAT_CYCLES + 1);
      end else begin
         hold_d = hold_q + TW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end

   assign step_c = edge_c | rpt_c;
`else
   logic [2:0]  unused_in;
   logic [31:0] unused_cfg;

   assign unused_in  = {other_i, en_i, clr_i};
   assign unused_cfg = 32'(HOLD_CYCLES) ^ 32'(REPEAT_CYCLES);
   assign step_c     = edge_c;
`endif

endmodule

// File: rtl/contador_datos_multi.sv
// Multi-channel up/down data counter driven by push-button steps.
// Build option: define AUTOREPEAT_EN for hold-to-repeat stepping.
// Ports:
//   clk, rst    clock, asynchronous active-low reset
//   en          step/load enable; clr clears all channels (priority over all)
//   sel         active channel; up/dn button levels; mode 0=wrap 1=saturate
//   load        load min(load_val, limit[sel]) into the selected channel
//   limit       per-channel max, channel i at [i*WIDTH +: WIDTH]
//   count_all   all counters (same packing); count_sel selected counter (comb)
//   wrap_pulse  registered 1-cycle pulse when the selected channel wraps
module contador_datos_multi
   import contador_pkg::*;
#(
   parameter  int unsigned WIDTH         = 7,
   parameter  int unsigned NUM_CH        = 4,
   parameter  int unsigned HOLD_CYCLES   = 50,
   parameter  int unsigned REPEAT_CYCLES = 10,
   localparam int unsigned SELW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    clr,
   input  logic [SELW-1:0]         sel,
   input  logic                    up,
   input  logic                    dn,
   input  logic                    mode,
   input  logic                    load,
   input  logic [WIDTH-1:0]        load_val,
   input  logic [NUM_CH*WIDTH-1:0] limit,
   output logic [NUM_CH*WIDTH-1:0] count_all,
   output logic [WIDTH-1:0]        count_sel,
   output logic                    wrap_pulse
);

   logic             up_step_c;
   logic             dn_step_c;
   step_e            step_c;
   logic             sel_ok_c;
   logic [WIDTH-1:0] cnt_q [NUM_CH];
   logic [WIDTH-1:0] cnt_d [NUM_CH];
   logic             wrap_d;
   logic [WIDTH:0]   nv_c;

   // Next value for one step: {wrap flag, new count}.
   function automatic logic [WIDTH:0] next_val(input logic [WIDTH-1:0] cnt,
                                               input logic [WIDTH-1:0] lim,
                                               input step_e            st,
                                               input logic             md);
      logic [WIDTH:0] r;
      r = {1'b0, cnt};
      case (st)
         STEP_UP: begin
            if (cnt < lim) begin
               r = {1'b0, cnt + WIDTH'(1)};
            end else if (md == MODE_WRAP) begin
               r = {1'b1, {WIDTH{1'b0}}};
            end else begin
               r = {1'b0, lim};
            end
         end
         STEP_DN: begin
            // A count above a lowered limit snaps back to the limit.
            if (cnt > lim) begin
               r = {1'b0, lim};
            end else if (cnt != '0) begin
               r = {1'b0, cnt - WIDTH'(1)};
            end else if (md == MODE_WRAP) begin
               r = {1'b1, lim};
            end else begin
               r = {1'b0, {WIDTH{1'b0}}};
            end
         end
         default: begin
            r = {1'b0, cnt};
         end
      endcase
      return r;
   endfunction

   key_step #(
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
   ) u_key_up (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (up),
      .other_i (dn),
      .en_i    (en),
      .clr_i   (clr),
      .step_c  (up_step_c)
   );

   key_step #(
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
   ) u_key_dn (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (dn),
      .other_i (up),
      .en_i    (en),
      .clr_i   (clr),
      .step_c  (dn_step_c)
   );

   assign step_c   = decode_step(up_step_c, dn_step_c);
   assign sel_ok_c = (32'(sel) < NUM_CH);

   // Next-state for the channel array: clr > load > step, selected channel only.
   always_comb begin
      wrap_d = 1'b0;
      nv_c   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i] = cnt_q[i];
      end
      if (clr) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = '0;
         end
      end else if (en && load) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (sel_ok_c && (sel == SELW'(i))) begin
               cnt_d[i] = (load_val > limit[i*WIDTH +: WIDTH]) ?
                          limit[i*WIDTH +: WIDTH] : load_val;
            end
         end
      end else if (en && sel_ok_c && (step_c != STEP_NONE)) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (sel == SELW'(i)) begin
               nv_c     = next_val(cnt_q[i], limit[i*WIDTH +: WIDTH], step_c, mode);
               cnt_d[i] = nv_c[WIDTH-1:0];
               wrap_d   = nv_c[WIDTH];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= '0;
         end
         wrap_pulse <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         wrap_pulse <= wrap_d;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
      assign count_all[g*WIDTH +: WIDTH] = cnt_q[g];
   end

   // Selected-channel view; reads 0 for an out-of-range index.
   always_comb begin
      count_sel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (sel_ok_c && (sel == SELW'(i))) begin
            count_sel = cnt_q[i];
         end
      end
   end

endmodule

// File: tb/tb_contador_datos_multi.sv
// Directed bench for contador_datos_multi (WIDTH=7, NUM_CH=4).
// Build option: define AUTOREPEAT_EN to check the hold-to-repeat result.
module tb_contador_datos_multi;

   localparam int unsigned W  = 7;
   localparam int unsigned NC = 4;

   logic          clk;
   logic          rst;
   logic          en;
   logic          clr;
   logic [1:0]    sel;
   logic          up;
   logic          dn;
   logic          mode;
   logic          load;
   logic [W-1:0]  load_val;
   logic [NC*W-1:0] limit;
   logic [NC*W-1:0] count_all;
   logic [W-1:0]  count_sel;
   logic          wrap_pulse;

   int n_assert;
   int n_fail;
   int exp_rep;

   contador_datos_multi dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .clr        (clr),
      .sel        (sel),
      .up         (up),
      .dn         (dn),
      .mode       (mode),
      .load       (load),
      .load_val   (load_val),
      .limit      (limit),
      .count_all  (count_all),
      .count_sel  (count_sel),
      .wrap_pulse (wrap_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ch(input int k);
      logic [NC*W-1:0] v;
      v = count_all;
      return 32'(v[k*W +: W]);
   endfunction

   function automatic logic [31:0] pack4(input int c3, input int c2, input int c1, input int c0);
      logic [NC*W-1:0] v;
      v = {W'(c3), W'(c2), W'(c1), W'(c0)};
      return 32'(v);
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input int s, input int v);
      sel      = 2'(s);
      load_val = W'(v);
      en       = 1'b1;
      load     = 1'b1;
      tick();
      load     = 1'b0;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst = 1'b0; en = 1'b0; clr = 1'b0; sel = '0; up = 1'b0; dn = 1'b0;
      mode = 1'b0; load = 1'b0; load_val = '0;
      limit = {7'd40, 7'd100, 7'd23, 7'd59};
      repeat (2) tick();
      chk("reset_counts", 32'(count_all), 0);
      chk("reset_wrap", 32'(wrap_pulse), 0);
      rst = 1'b1;
      tick();

      // Asynchronous reset mid-count
      do_load(0, 5);
      chk("load_ch0_5", 32'(count_sel), 5);
      rst = 1'b0;
      #2;
      chk("async_rst_counts", 32'(count_all), 0);
      chk("async_rst_wrap", 32'(wrap_pulse), 0);
      #2;
      rst = 1'b1;
      tick();
      chk("post_rst_counts", 32'(count_all), 0);

      // Wrap up at limit, then hold without further steps
      mode = 1'b0;
      do_load(0, 59);
      chk("load_ch0_59", ch(0), 59);
      up = 1'b1;
      tick();
      chk("wrap_up_value", ch(0), 0);
      chk("wrap_up_pulse", 32'(wrap_pulse), 1);
      tick();
      chk("wrap_pulse_one_cycle", 32'(wrap_pulse), 0);
      repeat (18) tick();
      chk("held_no_step", ch(0), 0);
      up = 1'b0;
      tick();

      // Saturate/wrap down on ch1, saturate up at limit
      do_load(1, 0);
      mode = 1'b1;
      dn = 1'b1;
      tick();
      chk("sat_dn_value", ch(1), 0);
      chk("sat_dn_pulse", 32'(wrap_pulse), 0);
      dn = 1'b0;
      tick();
      mode = 1'b0;
      dn = 1'b1;
      tick();
      chk("wrap_dn_value", ch(1), 23);
      chk("wrap_dn_pulse", 32'(wrap_pulse), 1);
      dn = 1'b0;
      tick();
      chk("wrap_dn_pulse_low", 32'(wrap_pulse), 0);
      mode = 1'b1;
      up = 1'b1;
      tick();
      chk("sat_up_value", ch(1), 23);
      chk("sat_up_pulse", 32'(wrap_pulse), 0);
      up = 1'b0;
      mode = 1'b0;
      tick();

      // Simultaneous up+dn
      do_load(2, 7);
      up = 1'b1;
      dn = 1'b1;
      tick();
      chk("both_no_change", ch(2), 7);
      chk("both_no_pulse", 32'(wrap_pulse), 0);
      up = 1'b0;
      dn = 1'b0;
      tick();

      // Load beats a wrapping step and suppresses the pulse
      do_load(0, 59);
      sel = 2'd0; load = 1'b1; load_val = 7'd12; up = 1'b1;
      tick();
      chk("load_over_step", ch(0), 12);
      chk("load_no_pulse", 32'(wrap_pulse), 0);
      load = 1'b0;
      up = 1'b0;
      tick();

      // Press while disabled is not replayed
      sel = 2'd2;
      en = 1'b0;
      up = 1'b1;
      tick();
      chk("en0_no_step", ch(2), 7);
      en = 1'b1;
      tick();
      chk("en0_not_replayed", ch(2), 7);
      up = 1'b0;
      tick();

      // Changing sel mid-press does not re-trigger
      up = 1'b1;
      tick();
      chk("ch2_step_up", ch(2), 8);
      sel = 2'd1;
      tick();
      chk("sel_change_ch1", ch(1), 23);
      chk("sel_change_ch2", ch(2), 8);
      up = 1'b0;
      tick();
      chk("all_channels", 32'(count_all), pack4(0, 8, 23, 12));

      // clr beats load and step
      sel = 2'd0; clr = 1'b1; load = 1'b1; load_val = 7'd5; up = 1'b1;
      tick();
      chk("clr_all_zero", 32'(count_all), 0);
      chk("clr_no_pulse", 32'(wrap_pulse), 0);
      clr = 1'b0;
      load = 1'b0;
      up = 1'b0;
      tick();

      // Limit lowered at runtime on ch3
      do_load(3, 40);
      chk("load_ch3_40", ch(3), 40);
      limit[3*W +: W] = 7'd30;
      dn = 1'b1;
      tick();
      chk("dn_above_limit", ch(3), 30);
      dn = 1'b0;
      tick();
      up = 1'b1;
      tick();
      chk("up_at_limit_wrap", ch(3), 0);
      chk("up_at_limit_pulse", 32'(wrap_pulse), 1);
      up = 1'b0;
      tick();
      do_load(3, 99);
      chk("load_clamped", 32'(count_sel), 30);
      limit[3*W +: W] = 7'd0;
      up = 1'b1;
      tick();
      chk("limit0_value", ch(3), 0);
      chk("limit0_pulse", 32'(wrap_pulse), 1);
      up = 1'b0;
      limit[3*W +: W] = 7'd30;
      tick();

      // Long hold on ch0
      do_load(0, 0);
      up = 1'b1;
      repeat (80) tick();
      up = 1'b0;
      tick();
`ifdef AUTOREPEAT_EN
      exp_rep = 4;
`else
      exp_rep = 1;
`endif
      chk("long_hold", ch(0), 32'(exp_rep));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
